// File: rtl/modulo_secded_pipe_if.sv
// Handshake/bus bundle for modulo_secded_pipe.
//   master : upstream/downstream environment (drives words in, accepts results)
//   slave  : the codec itself
// Signals:
//   in_valid/in_ready   input word handshake
//   modo, in_data       mode (0 encode, 1 decode) and word, sampled with in_valid
//   out_valid/out_ready result handshake
//   out_modo, out_data  mode and result of the word at the output
//   err_single, err_double, syndrome  decode status of the output word
//   inj_mask            codeword error injection (only with MODULO_SECDED_INJECT_EN)
interface modulo_secded_pipe_if #(
  parameter int DATA_W = 4
);
  function automatic int calc_pw(input int dw);
    int res;
    res = 0;
    for (int p = 1; p < 6; p++)
      if (res == 0 && (1 << p) >= dw + p + 1) res = p;
    return res;
  endfunction

  localparam int P_W    = calc_pw(DATA_W);
  localparam int CODE_W = DATA_W + P_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic              modo;
  logic [CODE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_modo;
  logic [CODE_W-1:0] out_data;
  logic              err_single;
  logic              err_double;
  logic [P_W-1:0]    syndrome;
`ifdef MODULO_SECDED_INJECT_EN
  logic [CODE_W-1:0] inj_mask;
`endif

  modport master (
    output in_valid, modo, in_data, out_ready,
`ifdef MODULO_SECDED_INJECT_EN
    output inj_mask,
`endif
    input  in_ready, out_valid, out_modo, out_data, err_single, err_double, syndrome
  );

  modport slave (
    input  in_valid, modo, in_data, out_ready,
`ifdef MODULO_SECDED_INJECT_EN
    input  inj_mask,
`endif
    output in_ready, out_valid, out_modo, out_data, err_single, err_double, syndrome
  );
endinterface

// File: rtl/modulo_secded_pipe.sv
// Two-stage pipelined SECDED (extended Hamming) encoder/decoder with
// valid/ready handshake on both sides and saturating error counters.
// Optional feature macro: MODULO_SECDED_INJECT_EN adds bus.inj_mask, XORed
// onto encode-mode codewords when they move from S1 to S2.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     word handshake, mode, data, result and decode status
//   cnt_clr         synchronous clear of both counters (wins over increment)
//   corr_cnt        corrected-word count, saturating
//   dbl_cnt         uncorrectable-word count, saturating
module modulo_secded_pipe #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  modulo_secded_pipe_if.slave bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  dbl_cnt
);
  function automatic int calc_pw(input int dw);
    int res;
    res = 0;
    for (int p = 1; p < 6; p++)
      if (res == 0 && (1 << p) >= dw + p + 1) res = p;
    return res;
  endfunction

  localparam int P_W    = calc_pw(DATA_W);
  localparam int CODE_W = DATA_W + P_W + 1;

  // Data bits fill the non-power-of-two positions from 3 upward; parity k
  // covers every position with index bit k set; bit 0 makes the word even.
  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic p;
    int j;
    c = '0;
    j = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < P_W; k++) begin
      p = 1'b0;
      for (int i = 1; i < CODE_W; i++)
        if ((((i >> k) & 1) != 0) && (i != (1 << k))) p = p ^ c[i];
      c[1 << k] = p;
    end
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] hamming_extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [P_W-1:0] calc_syn(input logic [CODE_W-1:0] c);
    logic [P_W-1:0] s;
    s = '0;
    for (int i = 1; i < CODE_W; i++)
      if (c[i]) s = s ^ P_W'(i);
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic              vld_p1, modo_p1, ov_p1;
  logic [CODE_W-1:0] word_p1;
  logic [P_W-1:0]    syn_p1;
  logic              vld_p2, modo_p2, es_p2, ed_p2;
  logic [CODE_W-1:0] data_p2;
  logic [P_W-1:0]    syn_p2;
  logic              adv_p2, in_ready;

  // S2 accepts whenever it is empty or its word leaves this cycle, so a full
  // pipe keeps streaming while out_ready is high.
  assign adv_p2   = !vld_p2 || bus.out_ready;
  assign in_ready = !vld_p1 || adv_p2;
  assign bus.in_ready = in_ready;

  // ---- S0 -> S1: capture word, mode, raw syndrome and overall parity ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid && in_ready) begin
      word_p1 <= bus.in_data;
      modo_p1 <= bus.modo;
      syn_p1  <= calc_syn(bus.in_data);
      ov_p1   <= ^bus.in_data;
    end
  end

  logic [CODE_W-1:0] corr_word, data_nxt;
  logic              es_nxt, ed_nxt, syn_in_range;
  logic [P_W-1:0]    syn_nxt;

  always_comb begin
    corr_word    = word_p1;
    data_nxt     = '0;
    es_nxt       = 1'b0;
    ed_nxt       = 1'b0;
    syn_nxt      = '0;
    syn_in_range = 1'b0;
    if (!modo_p1) begin
`ifdef MODULO_SECDED_INJECT_EN
      data_nxt = hamming_encode(word_p1[DATA_W-1:0]) ^ bus.inj_mask;
`else
      data_nxt = hamming_encode(word_p1[DATA_W-1:0]);
`endif
    end else begin
      syn_nxt = syn_p1;
      for (int i = 0; i < CODE_W; i++)
        if (int'(syn_p1) == i) syn_in_range = 1'b1;
      if (syn_p1 == '0) begin
        // Only bit 0 can be wrong here; data positions are intact.
        es_nxt = ov_p1;
      end else if (ov_p1 && syn_in_range) begin
        for (int i = 0; i < CODE_W; i++)
          if (int'(syn_p1) == i) corr_word[i] = ~word_p1[i];
        es_nxt = 1'b1;
      end else begin
        ed_nxt = 1'b1;
      end
      data_nxt = CODE_W'(hamming_extract(corr_word));
    end
  end

  // ---- S1 -> S2: register result and flags; hold while stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      modo_p2 <= 1'b0;
      data_p2 <= '0;
      es_p2   <= 1'b0;
      ed_p2   <= 1'b0;
      syn_p2  <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        modo_p2 <= modo_p1;
        data_p2 <= data_nxt;
        es_p2   <= es_nxt;
        ed_p2   <= ed_nxt;
        syn_p2  <= syn_nxt;
      end
    end
  end

  assign bus.out_valid  = vld_p2;
  assign bus.out_modo   = modo_p2;
  assign bus.out_data   = data_p2;
  assign bus.err_single = es_p2;
  assign bus.err_double = ed_p2;
  assign bus.syndrome   = syn_p2;

  // ---- S2 -> out: count errored decode words as they are handed off ----
  logic out_hs_dec;
  assign out_hs_dec = vld_p2 && bus.out_ready && modo_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
      dbl_cnt  <= '0;
    end else if (cnt_clr) begin
      corr_cnt <= '0;
      dbl_cnt  <= '0;
    end else if (out_hs_dec) begin
      if (es_p2) corr_cnt <= sat_inc(corr_cnt);
      if (ed_p2) dbl_cnt  <= sat_inc(dbl_cnt);
    end
  end
endmodule

// File: tb/tb_modulo_secded_pipe.sv
// Scoreboard bench for modulo_secded_pipe at DATA_W=4 (8-bit codewords).
// Stimulus pushes the expected output word into a queue on every accepted
// input; a negedge monitor pops and compares on every output handshake.
module tb_modulo_secded_pipe;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_cnt, dbl_cnt;

  modulo_secded_pipe_if #(.DATA_W(DATA_W)) bus();

  modulo_secded_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cnt_clr  (cnt_clr),
    .corr_cnt (corr_cnt),
    .dbl_cnt  (dbl_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic       m;
    logic [7:0] d;
    logic       es;
    logic       ed;
    logic [2:0] syn;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  exp_t mon_e;

  // Hand-computed DATA_W=4 codewords for data 0..15.
  logic [7:0] cw_tab [16] = '{8'h00, 8'h0F, 8'h33, 8'h3C, 8'h55, 8'h5A, 8'h66, 8'h69,
                              8'h96, 8'h99, 8'hA5, 8'hAA, 8'hC3, 8'hCC, 8'hF0, 8'hFF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t enc_exp(input logic [7:0] cw);
    return {1'b0, cw, 1'b0, 1'b0, 3'd0};
  endfunction

  function automatic exp_t dec_exp(input logic [7:0] d, input logic es, input logic ed,
                                   input logic [2:0] syn);
    return {1'b1, d, es, ed, syn};
  endfunction

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got modo=%0b data=0x%0h with no word expected",
                 bus.out_modo, bus.out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_word", 32'({bus.out_modo, bus.out_data, bus.err_single, bus.err_double,
                             bus.syndrome}), 32'(mon_e));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic m, input logic [7:0] d, input exp_t e);
    int n;
    bus.in_valid = 1'b1;
    bus.modo     = m;
    bus.in_data  = d;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected 1");
    end else begin
      sb.push_back(e);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] hold;
    int unstable, a0, span, n;

    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.modo      = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
`ifdef MODULO_SECDED_INJECT_EN
    bus.inj_mask  = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 1);
    chk("rst_out_data",  32'(bus.out_data), 0);
    chk("rst_out_modo",  32'(bus.out_modo), 0);
    chk("rst_flags",     32'({bus.err_single, bus.err_double}), 0);
    chk("rst_syndrome",  32'(bus.syndrome), 0);
    chk("rst_corr_cnt",  32'(corr_cnt), 0);
    chk("rst_dbl_cnt",   32'(dbl_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at edge E0, valid after E1.
    send(1'b0, 8'h0B, enc_exp(8'hAA));
    chk("lat_after_accept", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_two_clk", 32'(bus.out_valid), 1);
    drain();

    // Upper input bits are ignored for encode.
    send(1'b0, 8'hFB, enc_exp(8'hAA));
    drain();

    // Encode sweep, back to back.
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) send(1'b0, 8'(i), enc_exp(cw_tab[i]));
    drain();
    chk("sweep_count", 32'(pop_cyc.size()), 16);
    span = (pop_cyc.size() >= 16) ? pop_cyc[15] - pop_cyc[0] : -1;
    chk("sweep_one_per_clk", 32'(span), 15);

    // Every codeword decodes clean.
    for (int i = 0; i < 16; i++) send(1'b1, cw_tab[i], dec_exp(8'(i), 1'b0, 1'b0, 3'd0));
    drain();
    chk("clean_corr_cnt", 32'(corr_cnt), 0);
    chk("clean_dbl_cnt",  32'(dbl_cnt), 0);

    // Single errors: data bit 5, then overall parity bit 0.
    send(1'b1, 8'h8A, dec_exp(8'h0B, 1'b1, 1'b0, 3'd5));
    drain();
    chk("single_corr_cnt", 32'(corr_cnt), 1);
    send(1'b1, 8'hAB, dec_exp(8'h0B, 1'b1, 1'b0, 3'd0));
    drain();
    chk("bit0_corr_cnt", 32'(corr_cnt), 2);

    // Double error: uncorrected data bits come out.
    send(1'b1, 8'h82, dec_exp(8'h08, 1'b0, 1'b1, 3'd6));
    drain();
    chk("double_dbl_cnt",  32'(dbl_cnt), 1);
    chk("double_corr_cnt", 32'(corr_cnt), 2);

    // Backpressure: stall output 5 clk against a continuous stream.
    bus.out_ready = 1'b0;
    a0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, 8'(i + 2), enc_exp(cw_tab[i + 2]));
      end
    join_none
    hold = 8'h00;
    unstable = 0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (n == 0) hold = bus.out_data;
        else if (bus.out_data !== hold) unstable++;
        n++;
      end
    end
    chk("bp_accepted",  32'(acc_cnt - a0), 2);
    chk("bp_in_ready",  32'(bus.in_ready), 0);
    chk("bp_hold_word", 32'(hold), 32'h33);
    chk("bp_stable",    32'(unstable), 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    n = 0;
    while ((acc_cnt - a0) < 6 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("bp_all_accepted", 32'(acc_cnt - a0), 6);
    #2;
    drain();

    // Counter saturation.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_corr_cnt", 32'(corr_cnt), 0);
    chk("clr_dbl_cnt",  32'(dbl_cnt), 0);
    for (int i = 0; i < 255; i++) send(1'b1, 8'h8A, dec_exp(8'h0B, 1'b1, 1'b0, 3'd5));
    drain();
    chk("sat_reach_255", 32'(corr_cnt), 255);
    send(1'b1, 8'h8A, dec_exp(8'h0B, 1'b1, 1'b0, 3'd5));
    drain();
    chk("sat_hold_255", 32'(corr_cnt), 255);
    chk("sat_dbl_zero", 32'(dbl_cnt), 0);

    // Clear wins over a simultaneous increment.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    send(1'b1, 8'h8A, dec_exp(8'h0B, 1'b1, 1'b0, 3'd5));
    drain();
    chk("prio_pre_cnt", 32'(corr_cnt), 1);
    bus.out_ready = 1'b0;
    send(1'b1, 8'h8A, dec_exp(8'h0B, 1'b1, 1'b0, 3'd5));
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("prio_word_ready", 32'(bus.out_valid), 1);
    cnt_clr = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("prio_clr_wins", 32'(corr_cnt), 0);
    drain();

    // Reset with two words in flight.
    send(1'b1, 8'h82, dec_exp(8'h08, 1'b0, 1'b1, 3'd6));
    drain();
    chk("pre_rst_dbl_cnt", 32'(dbl_cnt), 1);
    bus.out_ready = 1'b0;
    send(1'b0, 8'h03, enc_exp(8'h3C));
    send(1'b0, 8'h05, enc_exp(8'h5A));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_in_ready",  32'(bus.in_ready), 1);
    chk("midrst_dbl_cnt",   32'(dbl_cnt), 0);
    chk("midrst_out_data",  32'(bus.out_data), 0);
    sb.delete();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_stale", 32'(bus.out_valid), 0);

    // Pipe still works after reset.
    send(1'b0, 8'h0B, enc_exp(8'hAA));
    drain();
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/modulo_secded_pipe.md
Name: modulo_secded_pipe

Overview:
- Parametrised, pipelined SECDED (extended Hamming) codec; successor to the fixed 4-to-8-bit combinational encoder.
- Per-transaction mode: encode DATA_W data bits to CODE_W codeword, or decode a CODE_W codeword with single-error correction and double-error detection.
- Valid/ready handshake on both sides; saturating error counters for board-level status display.

Parameters:
- DATA_W, 4, data bits per word; legal range 2..26.
- CNT_W, 8, width of each error counter.
- P_W, derived localparam (not overridable): smallest p with 2^p >= DATA_W+p+1. Equals 3 for DATA_W=4.
- CODE_W, derived localparam: DATA_W+P_W+1. Equals 8 for DATA_W=4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- modo  in  1  0 = encode, 1 = decode; sampled with in_data
- in_data  in  CODE_W  encode: bits [DATA_W-1:0] used, upper bits ignored; decode: full codeword
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_modo  out  1  mode of the word currently at the output
- out_data  out  CODE_W  encode: codeword; decode: corrected data, zero-extended
- err_single  out  1  decode only: single error found and corrected
- err_double  out  1  decode only: uncorrectable error
- syndrome  out  P_W  decode only: raw Hamming syndrome; 0 for encode
- cnt_clr  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  count of corrected words
- dbl_cnt  out  CNT_W  count of uncorrectable words

Behaviour:
- Codeword layout:
  - Bit i = Hamming position i for i >= 1. Parity bits sit at positions 2^k. Data bits d0.. fill the remaining positions in ascending order.
  - Bit 0 = overall even parity over bits [CODE_W-1:1].
  - p_k = XOR of all positions with bit k of the index set, excluding 2^k itself (even parity).
  - Example, DATA_W=4: 4'b1011 encodes to 8'hAA.
- Decode:
  - syn = XOR of the indices of all set bits in positions 1..CODE_W-1.
  - ov = XOR of all CODE_W bits.
  - syn=0, ov=0: clean; both error flags low.
  - syn!=0, ov=1, syn<CODE_W: flip bit syn; err_single=1.
  - syn=0, ov=1: error in bit 0; data unchanged; err_single=1.
  - syn!=0, ov=0: err_double=1; output uncorrected data bits.
  - syn>=CODE_W, ov=1: err_double=1.
- Pipeline, 2 stages:
  - S1 registers the input word, mode, syn and ov.
  - S2 registers the corrected/encoded result and the flags.
  - Latency: 2 clk from input handshake to out_valid, with out_ready held high.
  - Throughput: 1 word/clk.
- Handshake:
  - Transfer on valid&&ready at either port.
  - in_ready = !s1_valid || stage S1 can advance. It is combinational from out_ready; no bubble when the pipe is full and draining.
  - When out_valid=1 and out_ready=0, out_data, out_modo, the flags and syndrome hold stable.
  - in_valid must not depend on in_ready.
- Flags and syndrome are 0 for encode words. They are only meaningful while out_valid=1.
- Counters:
  - Increment on an output handshake of a decode word with the corresponding flag set.
  - Saturate at all-ones.
  - cnt_clr takes priority over a simultaneous increment; the result is 0.
- Reset (async assert, sync-safe deassert):
  - out_valid=0, in_ready=1 after reset, out_data=0, out_modo=0, flags=0, syndrome=0, counters=0.
  - Reset mid-operation discards in-flight words without a handshake.

Optional Feature:
- Macro: MODULO_SECDED_INJECT_EN.
- Defined: adds input inj_mask [CODE_W-1:0].
  - It is XORed onto the encode-mode codeword in S2, for self-test through an encode-then-decode loop.
  - It is sampled at the S1 to S2 transfer and ignored for decode words.
- Undefined: the port is absent and the codeword is emitted unmodified.

Test Plan:
- Encode sweep, DATA_W=4: inputs 0..15 back-to-back, out_ready=1.
  - 4'b1011 gives 8'hAA; 4'b0000 gives 8'h00.
  - First out_valid 2 clk after the first handshake.
  - Then 1 result per clk, and all 16 codewords decode clean.
- Single-error decode: 8'h8A (8'hAA with bit 5 flipped).
  - out_data=4'b1011, err_single=1, syndrome=5, corr_cnt increments 0 to 1.
  - Also 8'hAB (bit 0 flipped) gives data 4'b1011, err_single=1, syndrome=0.
- Double-error decode: 8'h82 (bits 5 and 3 flipped).
  - err_double=1, syndrome=6, dbl_cnt 0 to 1, corr_cnt unchanged.
- Backpressure:
  - Hold out_ready=0 for 5 clk with a continuous input stream.
  - in_ready drops after 2 words are accepted; out_data stays stable.
  - Releasing out_ready drains in order with no loss or duplication.
- Counter edges:
  - Force corr_cnt to 255 via 255 errored words; one more keeps it at 255.
  - Assert cnt_clr in the same clk as an increment: counter becomes 0.
- Reset mid-stream:
  - Deassert rst_n with 2 words in flight.
  - out_valid drops immediately, counters clear, and no stale word appears after release.
